// File: rtl/ov5642_pkg.sv
// Shared definitions for the OV5642 DVP link: FSM state encoding and default
// timing for the 1280x960 YUV422 mode (two bytes per pixel), also used by the
// receiver bench so both ends agree on frame geometry.
package ov5642_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBACK  = 3'd2,
        ST_LINE   = 3'd3,
        ST_HBLANK = 3'd4,
        ST_VFRONT = 3'd5
    } ov5642_state_e;

    localparam int OV5642_H_ACTIVE  = 2560;
    localparam int OV5642_V_ACTIVE  = 960;
    localparam int OV5642_H_BLANK   = 256;
    localparam int OV5642_VSYNC_LEN = 16;
    localparam int OV5642_V_BACK    = 64;
    localparam int OV5642_V_FRONT   = 64;

    function automatic int ov5642_max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Width of the shared in-state cycle counter: covers the longest phase.
    function automatic int ov5642_cnt_width(input int ha, input int hb, input int vs,
                                            input int vb, input int vf);
        int m;
        m = ov5642_max2(ov5642_max2(ha, hb), ov5642_max2(ov5642_max2(vs, vb), vf));
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/ov5642_tx_timing.sv
// Frame/line timing generator for the DVP transmitter.
// Latency: the FSM runs one cycle ahead of the output registers in the top.
// Backpressure: none; timing free-runs once a frame starts and never stalls.
module ov5642_tx_timing
    import ov5642_pkg::*;
#(
    parameter int  H_ACTIVE  = OV5642_H_ACTIVE,
    parameter int  V_ACTIVE  = OV5642_V_ACTIVE,
    parameter int  H_BLANK   = OV5642_H_BLANK,
    parameter int  VSYNC_LEN = OV5642_VSYNC_LEN,
    parameter int  V_BACK    = OV5642_V_BACK,
    parameter int  V_FRONT   = OV5642_V_FRONT,
    localparam int CW = ov5642_cnt_width(H_ACTIVE, H_BLANK, VSYNC_LEN, V_BACK, V_FRONT),
    localparam int LW = $clog2(V_ACTIVE) + 1
) (
    input  logic          pclk,
    input  logic          rst_n,
    input  logic          enable_i,
    output logic          href_next_o,
    output logic          vsync_next_o,
    output logic          tready_next_o,
    output logic [CW-1:0] byte_idx_o,
    output logic [LW-1:0] line_idx_o
);

    ov5642_state_e state_q;
    logic [CW-1:0] cnt_q;
    logic [LW-1:0] line_q;

    // Phase sequencer: each state lasts a fixed number of cycles counted by cnt_q;
    // enable is only looked at when leaving IDLE or at the end of the front porch.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            line_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (enable_i) begin
                        state_q <= ST_VSYNC;
                    end
                end
                ST_VSYNC: begin
                    if (cnt_q == CW'(VSYNC_LEN - 1)) begin
                        state_q <= ST_VBACK;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_VBACK: begin
                    if (cnt_q == CW'(V_BACK - 1)) begin
                        state_q <= ST_LINE;
                        cnt_q   <= '0;
                        line_q  <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_LINE: begin
                    if (cnt_q == CW'(H_ACTIVE - 1)) begin
                        cnt_q   <= '0;
                        state_q <= (line_q == LW'(V_ACTIVE - 1)) ? ST_VFRONT : ST_HBLANK;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_HBLANK: begin
                    if (cnt_q == CW'(H_BLANK - 1)) begin
                        state_q <= ST_LINE;
                        cnt_q   <= '0;
                        line_q  <= line_q + LW'(1);
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_VFRONT: begin
                    if (cnt_q == CW'(V_FRONT - 1)) begin
                        cnt_q   <= '0;
                        state_q <= enable_i ? ST_VSYNC : ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    line_q  <= '0;
                end
            endcase
        end
    end

    assign href_next_o  = (state_q == ST_LINE);
    assign vsync_next_o = (state_q == ST_VSYNC);
    assign byte_idx_o   = cnt_q;
    assign line_idx_o   = line_q;

    // True when the FSM will be in LINE after this edge, so the top can raise
    // s_tready exactly one cycle ahead of each href cycle.
    assign tready_next_o = ((state_q == ST_VBACK)  && (cnt_q == CW'(V_BACK - 1)))  ||
                           ((state_q == ST_HBLANK) && (cnt_q == CW'(H_BLANK - 1))) ||
                           ((state_q == ST_LINE)   && (cnt_q != CW'(H_ACTIVE - 1)));

endmodule

// File: rtl/ov5642_dvp_transmitter.sv
// OV5642 DVP camera emulator: AXI-stream bytes out on dout/href/vsync.
// Latency: a byte handshaken in cycle n is on dout with href=1 in cycle n+1.
// Backpressure: none towards DVP; empty slots send 0x00 and set sticky underrun.
// Build option OV5642_TX_TEST_PATTERN_EN replaces the stream with (line+byte) mod 256.
module ov5642_dvp_transmitter
    import ov5642_pkg::*;
#(
    parameter int  H_ACTIVE  = OV5642_H_ACTIVE,
    parameter int  V_ACTIVE  = OV5642_V_ACTIVE,
    parameter int  H_BLANK   = OV5642_H_BLANK,
    parameter int  VSYNC_LEN = OV5642_VSYNC_LEN,
    parameter int  V_BACK    = OV5642_V_BACK,
    parameter int  V_FRONT   = OV5642_V_FRONT,
    localparam int CW = ov5642_cnt_width(H_ACTIVE, H_BLANK, VSYNC_LEN, V_BACK, V_FRONT),
    localparam int LW = $clog2(V_ACTIVE) + 1
) (
    input  logic       pclk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [7:0] s_tdata,
    input  logic       s_tvalid,
    output logic       s_tready,
    input  logic       s_tlast,
    output logic [7:0] dout,
    output logic       href,
    output logic       vsync,
    output logic       underrun,
    output logic       line_err
);

    logic          href_next;
    logic          vsync_next;
    logic          tready_next;
    logic [CW-1:0] byte_idx;
    logic [LW-1:0] line_idx;

    logic       href_q;
    logic       vsync_q;
    logic [7:0] dout_q;
    logic       tready_q;
    logic       underrun_q;
    logic       line_err_q;

    ov5642_tx_timing #(
        .H_ACTIVE  (H_ACTIVE),
        .V_ACTIVE  (V_ACTIVE),
        .H_BLANK   (H_BLANK),
        .VSYNC_LEN (VSYNC_LEN),
        .V_BACK    (V_BACK),
        .V_FRONT   (V_FRONT)
    ) u_timing (
        .pclk          (pclk),
        .rst_n         (rst_n),
        .enable_i      (enable),
        .href_next_o   (href_next),
        .vsync_next_o  (vsync_next),
        .tready_next_o (tready_next),
        .byte_idx_o    (byte_idx),
        .line_idx_o    (line_idx)
    );

`ifdef OV5642_TX_TEST_PATTERN_EN
    logic [7:0] pattern_byte;
    logic       unused_stream;

    assign pattern_byte  = 8'(line_idx) + 8'(byte_idx);
    assign unused_stream = ^{s_tdata, s_tvalid, s_tlast, tready_next};

    // Output stage, pattern build: sync strobes plus a generated ramp per line.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            href_q     <= 1'b0;
            vsync_q    <= 1'b0;
            dout_q     <= 8'h00;
            tready_q   <= 1'b0;
            underrun_q <= 1'b0;
            line_err_q <= 1'b0;
        end else begin
            href_q     <= href_next;
            vsync_q    <= vsync_next;
            dout_q     <= href_next ? pattern_byte : 8'h00;
            tready_q   <= 1'b0;
            underrun_q <= 1'b0;
            line_err_q <= 1'b0;
        end
    end
`else
    logic last_pos;
    logic unused_line_idx;

    // tready_q is high exactly in the cycle whose handshake fills the next href slot,
    // and byte_idx is that slot's position within the line.
    assign last_pos        = (byte_idx == CW'(H_ACTIVE - 1));
    assign unused_line_idx = ^line_idx;

    // Output stage, stream build: sync strobes, data mux, sticky underrun, tlast check.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            href_q     <= 1'b0;
            vsync_q    <= 1'b0;
            dout_q     <= 8'h00;
            tready_q   <= 1'b0;
            underrun_q <= 1'b0;
            line_err_q <= 1'b0;
        end else begin
            href_q     <= href_next;
            vsync_q    <= vsync_next;
            tready_q   <= tready_next;
            dout_q     <= (tready_q && s_tvalid) ? s_tdata : 8'h00;
            if (tready_q && !s_tvalid) begin
                underrun_q <= 1'b1;
            end
            line_err_q <= tready_q && s_tvalid && (s_tlast != last_pos);
        end
    end
`endif

    assign s_tready = tready_q;
    assign dout     = dout_q;
    assign href     = href_q;
    assign vsync    = vsync_q;
    assign underrun = underrun_q;
    assign line_err = line_err_q;

endmodule

// File: tb/tb_ov5642_dvp_transmitter.sv
// Self-checking bench for ov5642_dvp_transmitter with a small 4x2 frame.
// Expected outputs come from a frame-geometry model (plain arithmetic on the
// position within the frame) and the per-slot stimulus tables.
module tb_ov5642_dvp_transmitter;

    localparam int HA = 4, VA = 2, HB = 3, VS = 5, VB = 4, VF = 2;
    localparam int P  = VS + VB + VA * HA + (VA - 1) * HB + VF;
    localparam int NSLOT = VA * HA;

    logic       pclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] s_tdata = 8'h00;
    logic       s_tvalid = 1'b0;
    logic       s_tlast = 1'b0;
    logic       s_tready;
    logic [7:0] dout;
    logic       href;
    logic       vsync;
    logic       underrun;
    logic       line_err;

    int n_checks = 0;
    int n_fail   = 0;
    bit exp_ur   = 1'b0;

    bit         slot_vld [NSLOT];
    logic [7:0] slot_dat [NSLOT];
    bit         slot_last[NSLOT];

    always #5 pclk = ~pclk;

    ov5642_dvp_transmitter #(
        .H_ACTIVE (HA), .V_ACTIVE (VA), .H_BLANK (HB),
        .VSYNC_LEN(VS), .V_BACK   (VB), .V_FRONT (VF)
    ) dut (
        .pclk     (pclk),
        .rst_n    (rst_n),
        .enable   (enable),
        .s_tdata  (s_tdata),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .s_tlast  (s_tlast),
        .dout     (dout),
        .href     (href),
        .vsync    (vsync),
        .underrun (underrun),
        .line_err (line_err)
    );

    // Frame model: f is the output cycle counted from the vsync rise.
    function automatic bit m_vsync(input int f);
        return (f >= 0) && (f < VS);
    endfunction

    function automatic bit m_href(input int f);
        int u;
        u = f - VS - VB;
        if (u < 0 || u >= VA * HA + (VA - 1) * HB) return 1'b0;
        return (u % (HA + HB)) < HA;
    endfunction

    function automatic int m_slot(input int f);
        int u;
        u = f - VS - VB;
        return (u / (HA + HB)) * HA + (u % (HA + HB));
    endfunction

    // Default stream: bytes 1..8 in order, all valid, tlast on every line end.
    task automatic load_clean();
        for (int s = 0; s < NSLOT; s++) begin
            slot_vld[s]  = 1'b1;
            slot_dat[s]  = 8'(s + 1);
            slot_last[s] = ((s % HA) == HA - 1);
        end
    endtask

    // Raise enable in IDLE; vsync must still be low right after it is sampled.
    task automatic start_frame();
        @(negedge pclk);
        enable   = 1'b1;
        s_tvalid = 1'b0;
        @(posedge pclk); #1;
        n_checks++;
        if (vsync !== 1'b0 || href !== 1'b0) begin
            n_fail++;
            $display("FAIL pre_vsync: vsync=%0b href=%0b required 0/0", vsync, href);
        end
    endtask

    // Plays one frame, checking every output each cycle. stop_at>=0 returns early;
    // drop_en_at>=0 clears enable at that position.
    task automatic play_frame(input int stop_at, input int drop_en_at);
        int s;
        bit ev, eh, er, el;
        logic [7:0] ed;
        for (int f = 0; f < P; f++) begin
            @(negedge pclk);
            if (f == drop_en_at) enable = 1'b0;
            if (m_href(f)) begin
                s        = m_slot(f);
                s_tvalid = slot_vld[s];
                s_tdata  = slot_dat[s];
                s_tlast  = slot_last[s];
            end else begin
                s_tvalid = 1'($urandom_range(0, 1));
                s_tdata  = 8'($urandom);
                s_tlast  = 1'($urandom_range(0, 1));
            end
            @(posedge pclk); #1;
            ev = m_vsync(f);
            eh = m_href(f);
            ed = 8'h00;
            el = 1'b0;
`ifdef OV5642_TX_TEST_PATTERN_EN
            er = 1'b0;
            if (eh) begin
                s  = m_slot(f);
                ed = 8'((s / HA) + (s % HA));
            end
`else
            er = m_href(f + 1);
            if (eh) begin
                s = m_slot(f);
                if (slot_vld[s]) begin
                    ed = slot_dat[s];
                    el = (slot_last[s] != ((s % HA) == HA - 1));
                end else begin
                    exp_ur = 1'b1;
                end
            end
`endif
            n_checks++;
            if (vsync !== ev) begin
                n_fail++; $display("FAIL vsync f=%0d: got %0b required %0b", f, vsync, ev);
            end
            n_checks++;
            if (href !== eh) begin
                n_fail++; $display("FAIL href f=%0d: got %0b required %0b", f, href, eh);
            end
            n_checks++;
            if (dout !== ed) begin
                n_fail++; $display("FAIL dout f=%0d: got %02h required %02h", f, dout, ed);
            end
            n_checks++;
            if (s_tready !== er) begin
                n_fail++; $display("FAIL s_tready f=%0d: got %0b required %0b", f, s_tready, er);
            end
            n_checks++;
            if (underrun !== exp_ur) begin
                n_fail++; $display("FAIL underrun f=%0d: got %0b required %0b", f, underrun, exp_ur);
            end
            n_checks++;
            if (line_err !== el) begin
                n_fail++; $display("FAIL line_err f=%0d: got %0b required %0b", f, line_err, el);
            end
            if (f == stop_at) return;
        end
    endtask

    task automatic check_idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge pclk); #1;
            n_checks++;
            if (vsync !== 1'b0 || href !== 1'b0 || s_tready !== 1'b0) begin
                n_fail++;
                $display("FAIL idle cycle %0d: vsync=%0b href=%0b s_tready=%0b required 0", i, vsync, href, s_tready);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge pclk);
        rst_n    = 1'b0;
        enable   = 1'b0;
        s_tvalid = 1'b0;
        exp_ur   = 1'b0;
        repeat (2) @(negedge pclk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge pclk);
        #1;
        n_checks++;
        if ({vsync, href, s_tready, underrun, line_err} !== 5'b0 || dout !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_state: vsync=%0b href=%0b rdy=%0b ur=%0b le=%0b dout=%02h required all 0",
                     vsync, href, s_tready, underrun, line_err, dout);
        end
        @(negedge pclk);
        rst_n = 1'b1;
        check_idle(4);
    endtask

    // Two back-to-back frames prove the 22-cycle period, then enable drops.
    task automatic test_basic();
        load_clean();
        start_frame();
        play_frame(-1, -1);
        play_frame(-1, 1);
        check_idle(6);
    endtask

    task automatic test_underrun();
        load_clean();
        slot_vld[1] = 1'b0;
        slot_dat[2] = 8'h02;
        slot_dat[3] = 8'h03;
        start_frame();
        play_frame(-1, -1);
        load_clean();
        play_frame(-1, 1);
        check_idle(3);
        do_reset();
        @(posedge pclk); #1;
        n_checks++;
        if (underrun !== 1'b0) begin
            n_fail++; $display("FAIL underrun_clear: got %0b required 0", underrun);
        end
    endtask

    task automatic test_tlast();
        load_clean();
        slot_last[2] = 1'b1;
        slot_last[3] = 1'b0;
        start_frame();
        play_frame(-1, 2);
        check_idle(3);
    endtask

    task automatic test_enable_drop();
        load_clean();
        start_frame();
        play_frame(-1, VS + VB + HA + HB + 1);
        check_idle(10);
        start_frame();
        play_frame(-1, 0);
        check_idle(3);
    endtask

    task automatic test_reset_midline();
        load_clean();
        start_frame();
        play_frame(VS + VB + 1, -1);
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (href !== 1'b0 || vsync !== 1'b0 || dout !== 8'h00 || s_tready !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: href=%0b vsync=%0b dout=%02h rdy=%0b required 0",
                     href, vsync, dout, s_tready);
        end
        exp_ur   = 1'b0;
        s_tvalid = 1'b0;
        repeat (2) @(negedge pclk);
        rst_n = 1'b1;
        @(posedge pclk); #1;
        n_checks++;
        if (vsync !== 1'b0) begin
            n_fail++; $display("FAIL rst_pre_vsync: got %0b required 0", vsync);
        end
        play_frame(-1, 3);
        check_idle(3);
    endtask

    task automatic test_back_to_back_random();
        start_frame();
        for (int fr = 0; fr < 4; fr++) begin
            for (int s = 0; s < NSLOT; s++) begin
                slot_vld[s]  = ($urandom_range(0, 3) != 0);
                slot_dat[s]  = 8'($urandom);
                slot_last[s] = ((s % HA) == HA - 1) ^ ($urandom_range(0, 5) == 0);
            end
            play_frame(-1, (fr == 3) ? 1 : -1);
        end
        check_idle(4);
        do_reset();
    endtask

`ifdef OV5642_TX_TEST_PATTERN_EN
    task automatic test_pattern();
        start_frame();
        play_frame(-1, 1);
        check_idle(3);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_underrun();
        test_tlast();
        test_enable_drop();
        test_reset_midline();
        test_back_to_back_random();
`ifdef OV5642_TX_TEST_PATTERN_EN
        test_pattern();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
